// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The state encoding and the default-width entry layout are shared by the fetch logic and its users.
package fetch_unit_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_ISSUE = 2'd0;
    localparam fetch_state_t S_WAIT  = 2'd1;
    localparam fetch_state_t S_DROP  = 2'd2;

    localparam int PC_INC = 4;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;

    // Layout of one fetch-buffer entry at the default widths; fetch_unit rebuilds it per its parameters.
    typedef struct packed {
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_ADDR_W-1:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered fetch buffer: DEPTH x W entries with flush, push, pop and occupancy count.
// Outputs read zero while empty so downstream never sees stale entries.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign do_pop  = pop && valid && !flush;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && ((count < CW'(DEPTH)) || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-outstanding imem requests, redirect handling and IF/ID fetch buffer.
// Optional FETCH_BOOT_PC_EN adds a boot_pc port that supplies the PC while reset is held.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc4,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_taken,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              jr_taken,
    input  logic [ADDR_W-1:0] jr_target
`ifdef FETCH_BOOT_PC_EN
    ,
    input  logic [ADDR_W-1:0] boot_pc
`endif
);

    localparam int                CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);
    localparam logic [CW:0]       DEPTH_X    = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc4;
    } entry_t;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] reset_pc;
    logic              redirect;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_valid;
    logic [CW-1:0]     count;
    logic [CW:0]       count_after;
    entry_t            push_entry;
    entry_t            head;

`ifdef FETCH_BOOT_PC_EN
    assign reset_pc = boot_pc & ALIGN_MASK;
`else
    assign reset_pc = RESET_PC & ALIGN_MASK;
`endif

    assign redirect = jr_taken | jmp_taken | br_taken;

    always_comb begin
        if (jr_taken) begin
            target = jr_target;
        end else if (jmp_taken) begin
            target = jmp_target;
        end else begin
            target = br_target;
        end
    end

    // A redirect flushes the buffer, so it also cancels any pop and any push of that cycle.
    assign pop  = fifo_valid && id_ready && !redirect;
    assign push = (state == S_WAIT) && imem_rvalid && !redirect;

    // Occupancy once this cycle's response is pushed and any pop is taken.
    assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

    always_comb begin
        issue = 1'b0;
        case (state)
            S_ISSUE: issue = (count < CW'(FIFO_DEPTH));
            S_WAIT:  issue = imem_rvalid && (count_after < DEPTH_X);
            default: issue = 1'b0;
        endcase
        if (redirect) begin
            issue = 1'b0;
        end
    end

    assign imem_req  = issue && rst_n;
    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        pc_next    = issue ? pc + INC : pc;
        if (redirect) begin
            pc_next = target & ALIGN_MASK;
            // An outstanding request still owes a response that must be swallowed.
            if ((state == S_WAIT || state == S_DROP) && !imem_rvalid) begin
                state_next = S_DROP;
            end else begin
                state_next = S_ISSUE;
            end
        end else begin
            case (state)
                S_ISSUE: if (issue) state_next = S_WAIT;
                S_WAIT:  if (imem_rvalid) state_next = issue ? S_WAIT : S_ISSUE;
                S_DROP:  if (imem_rvalid) state_next = S_ISSUE;
                default: state_next = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_ISSUE;
            pc       <= reset_pc;
            req_addr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (issue) begin
                req_addr <= pc;
            end
        end
    end

    assign push_entry.inst = imem_rdata;
    assign push_entry.pc4  = req_addr + INC;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .valid (fifo_valid),
        .count (count)
    );

    assign if_valid = fifo_valid;
    assign if_inst  = head.inst;
    assign if_pc4   = head.pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model returning ~addr as the instruction.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_ready = 1'b1;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp_taken = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        jr_taken = 1'b0;
    logic [31:0] jr_target = '0;
`ifdef FETCH_BOOT_PC_EN
    logic [31:0] boot_pc = '0;
    localparam logic [31:0] EXP_START = 32'h400;
`else
    localparam logic [31:0] EXP_START = 32'h0;
`endif

    int total = 0;
    int bad = 0;
    int lat = 1;

    logic [31:0] req_q[$];
    logic [31:0] pop_pc4[$];
    logic [31:0] pop_inst[$];

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc4      (if_pc4),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_taken   (jmp_taken),
        .jmp_target  (jmp_target),
        .jr_taken    (jr_taken),
        .jr_target   (jr_target)
`ifdef FETCH_BOOT_PC_EN
        ,
        .boot_pc     (boot_pc)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: request seen at an edge is answered lat cycles later for one cycle.
    logic        m_req;
    logic        m_vld;
    logic [31:0] m_addr;
    logic        m_busy = 1'b0;
    int          m_remain = 0;
    logic [31:0] m_raddr = '0;

    always @(posedge clk) begin
        m_req  = imem_req;
        m_addr = imem_addr;
        m_vld  = imem_rvalid;
        #1;
        imem_rvalid = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else begin
            if (m_vld) m_busy = 1'b0;
            if (m_req) begin
                m_busy   = 1'b1;
                m_remain = lat - 1;
                m_raddr  = m_addr;
            end else if (m_busy && m_remain > 0) begin
                m_remain = m_remain - 1;
            end
            if (m_busy && m_remain == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~m_raddr;
            end
        end
    end

    // Transaction log: issued addresses and accepted (non-flushed) pops.
    always @(posedge clk) begin
        if (rst_n) begin
            if (imem_req) req_q.push_back(imem_addr);
            if (if_valid && id_ready && !(br_taken || jmp_taken || jr_taken)) begin
                pop_pc4.push_back(if_pc4);
                pop_inst.push_back(if_inst);
            end
        end
    end

    task automatic do_reset(input int l);
        @(posedge clk); #2;
        rst_n = 1'b0; id_ready = 1'b1;
        br_taken = 1'b0; jmp_taken = 1'b0; jr_taken = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        lat = l;
        req_q.delete(); pop_pc4.delete(); pop_inst.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(posedge clk);
        @(posedge clk); #5;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", if_valid); end
        total++; if (if_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%0h exp=0", if_inst); end
        total++; if (if_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%0h exp=0", if_pc4); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
    endtask

    task automatic test_stream;
        do_reset(1);
        repeat (12) @(posedge clk);
        #3;
        total++; if (req_q.size() != 12) begin bad++; $display("FAIL stream_req_count got=%0d exp=12", req_q.size()); end
        total++; if (pop_pc4.size() != 10) begin bad++; $display("FAIL stream_pop_count got=%0d exp=10", pop_pc4.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (req_q.size() <= i || req_q[i] !== 32'(4 * i)) begin
                bad++; $display("FAIL stream_addr[%0d] got=%0h exp=%0h", i, (req_q.size() > i) ? req_q[i] : 32'hx, 4 * i);
            end
            total++;
            if (pop_pc4.size() <= i || pop_pc4[i] !== 32'(4 * i + 4) || pop_inst[i] !== ~32'(4 * i)) begin
                bad++; $display("FAIL stream_pop[%0d] got=%0h exp=%0h", i, (pop_pc4.size() > i) ? pop_pc4[i] : 32'hx, 4 * i + 4);
            end
        end
    endtask

    task automatic test_stall;
        do_reset(1);
        id_ready = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        total++; if (req_q.size() != 4) begin bad++; $display("FAIL stall_req_count got=%0d exp=4", req_q.size()); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%0h exp=0", imem_req); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0h exp=1", if_valid); end
        total++; if (if_pc4 !== 32'h4 || if_inst !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stall_head got=%0h/%0h exp=4/ffffffff", if_pc4, if_inst); end
        @(posedge clk); #2;
        id_ready = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        total++; if (pop_pc4.size() < 6) begin bad++; $display("FAIL stall_drain_count got=%0d exp>=6", pop_pc4.size()); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (pop_pc4.size() <= i || pop_pc4[i] !== 32'(4 * i + 4)) begin
                bad++; $display("FAIL stall_drain[%0d] got=%0h exp=%0h", i, (pop_pc4.size() > i) ? pop_pc4[i] : 32'hx, 4 * i + 4);
            end
        end
        total++; if (req_q.size() < 5 || req_q[4] !== 32'h10) begin bad++; $display("FAIL stall_resume got=%0h exp=10", (req_q.size() > 4) ? req_q[4] : 32'hx); end
    endtask

    task automatic test_branch;
        do_reset(3);
        @(posedge clk); #2;
        br_taken = 1'b1; br_target = 32'h40;
        @(posedge clk); #2;
        br_taken = 1'b0;
        #3;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL branch_drop_req got=%0h exp=0", imem_req); end
        repeat (12) @(posedge clk);
        #3;
        total++; if (req_q.size() < 2 || req_q[0] !== 32'h0 || req_q[1] !== 32'h40) begin
            bad++; $display("FAIL branch_addr got=%0h exp=40", (req_q.size() > 1) ? req_q[1] : 32'hx);
        end
        total++; if (pop_pc4.size() < 1 || pop_pc4[0] !== 32'h44 || pop_inst[0] !== 32'hFFFF_FFBF) begin
            bad++; $display("FAIL branch_first_pop got=%0h exp=44", (pop_pc4.size() > 0) ? pop_pc4[0] : 32'hx);
        end
    endtask

    task automatic test_priority;
        do_reset(1);
        repeat (3) @(posedge clk);
        #2;
        jr_taken = 1'b1; jr_target = 32'h100;
        jmp_taken = 1'b1; jmp_target = 32'h200;
        br_taken = 1'b1; br_target = 32'h300;
        #3;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL prio_noissue got=%0h exp=0", imem_req); end
        @(posedge clk); #2;
        jr_taken = 1'b0; jmp_taken = 1'b0; br_taken = 1'b0;
        #3;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL prio_addr got=%0h/%0h exp=1/100", imem_req, imem_addr); end
        repeat (8) @(posedge clk);
        #3;
        total++; if (req_q.size() < 4 || req_q[3] !== 32'h100) begin bad++; $display("FAIL prio_log got=%0h exp=100", (req_q.size() > 3) ? req_q[3] : 32'hx); end
        total++; if (pop_pc4.size() < 2 || pop_pc4[0] !== 32'h4 || pop_pc4[1] !== 32'h104) begin
            bad++; $display("FAIL prio_pop got=%0h exp=104", (pop_pc4.size() > 1) ? pop_pc4[1] : 32'hx);
        end
    endtask

    task automatic test_wrap;
        do_reset(1);
        jmp_taken = 1'b1; jmp_target = 32'hFFFF_FFFF;
        @(posedge clk); #2;
        jmp_taken = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        total++; if (req_q.size() < 2 || req_q[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%0h exp=fffffffc", (req_q.size() > 0) ? req_q[0] : 32'hx); end
        total++; if (req_q.size() < 2 || req_q[1] !== 32'h0) begin bad++; $display("FAIL wrap_next got=%0h exp=0", (req_q.size() > 1) ? req_q[1] : 32'hx); end
        total++; if (pop_pc4.size() < 1 || pop_pc4[0] !== 32'h0 || pop_inst[0] !== 32'h3) begin
            bad++; $display("FAIL wrap_pc4 got=%0h exp=0", (pop_pc4.size() > 0) ? pop_pc4[0] : 32'hx);
        end
    endtask

    task automatic test_async_reset;
        do_reset(1);
        id_ready = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        total++; if (if_valid !== 1'b1 || if_pc4 !== 32'h4) begin bad++; $display("FAIL areset_full got=%0h/%0h exp=1/4", if_valid, if_pc4); end
        #1;
`ifdef FETCH_BOOT_PC_EN
        boot_pc = 32'h400;
`endif
        rst_n = 1'b0;
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%0h exp=0", if_valid); end
        total++; if (if_inst !== 32'h0 || if_pc4 !== 32'h0) begin bad++; $display("FAIL areset_head got=%0h/%0h exp=0/0", if_inst, if_pc4); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL areset_req got=%0h exp=0", imem_req); end
        total++; if (imem_addr !== EXP_START) begin bad++; $display("FAIL areset_pc got=%0h exp=%0h", imem_addr, EXP_START); end
        @(posedge clk);
        @(posedge clk); #2;
        req_q.delete(); pop_pc4.delete(); pop_inst.delete();
        id_ready = 1'b1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        total++; if (req_q.size() < 2 || req_q[0] !== EXP_START || req_q[1] !== EXP_START + 32'h4) begin
            bad++; $display("FAIL areset_first_addr got=%0h exp=%0h", (req_q.size() > 0) ? req_q[0] : 32'hx, EXP_START);
        end
        total++; if (pop_pc4.size() < 1 || pop_pc4[0] !== EXP_START + 32'h4) begin
            bad++; $display("FAIL areset_first_pop got=%0h exp=%0h", (pop_pc4.size() > 0) ? pop_pc4[0] : 32'hx, EXP_START + 32'h4);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_priority();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
